// File: rtl/dpram_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : dpram_fifo                                                 |
// | Description : Synchronous single-clock FIFO on an inferred dual-port     |
// |               RAM. Tracks occupancy and drives full/empty/almost flags.  |
// |               Overflow and underflow flags are sticky. The read mode is  |
// |               selectable: registered read (FWFT=0) or first-word-fall-   |
// |               through (FWFT=1).                                          |
// | Ports       : ck_i          clock, all logic on its rising edge          |
// |               rst_n_i       synchronous reset, active low                |
// |               clr_i         synchronous flush; RAM contents are kept     |
// |               we_i/wdata_i  push request / push data                     |
// |               re_i          pop request (FWFT=1: acknowledge head word)  |
// |               rdata_o       read data                                    |
// |               rvalid_o      rdata_o holds a valid word                   |
// |               full_o, afull_o, empty_o, aempty_o  occupancy flags        |
// |               count_o       words pushed and not yet popped (0..SIZE)    |
// |               overflow_o    sticky: push attempted while full            |
// |               underflow_o   sticky: pop attempted with nothing to pop    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module dpram_fifo #(
   parameter int BITS   = 16,
   parameter int SIZE   = 256,
   parameter int AWIDTH = $clog2(SIZE),
   parameter int AFULL  = SIZE - 4,
   parameter int AEMPTY = 4,
   parameter bit FWFT   = 1'b0
) (
   input  logic              ck_i,
   input  logic              rst_n_i,
   input  logic              clr_i,
   input  logic              we_i,
   input  logic [BITS-1:0]   wdata_i,
   output logic              full_o,
   output logic              afull_o,
   input  logic              re_i,
   output logic [BITS-1:0]   rdata_o,
   output logic              rvalid_o,
   output logic              empty_o,
   output logic              aempty_o,
   output logic [AWIDTH:0]   count_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam logic [AWIDTH:0] c_size   = (AWIDTH+1)'(SIZE);
   localparam logic [AWIDTH:0] c_afull  = (AWIDTH+1)'(AFULL);
   localparam logic [AWIDTH:0] c_aempty = (AWIDTH+1)'(AEMPTY);

   logic [BITS-1:0]   mem_q [SIZE];
   logic [AWIDTH-1:0] wptr_q, wptr_d;
   logic [AWIDTH-1:0] rptr_q, rptr_d;
   logic [AWIDTH:0]   count_q, count_d;
   logic              rvalid_q, rvalid_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;
   logic [BITS-1:0]   rdata_q;

   logic w_full;
   logic w_empty;
   logic w_flush;
   logic w_push;   // accepted push
   logic w_pop;    // accepted pop (count decrements)
   logic w_rd;     // RAM read into the output register
   logic w_udf;    // rejected pop request

   assign w_full  = (count_q == c_size);
   assign w_empty = (count_q == '0);
   assign w_flush = !rst_n_i || clr_i;
   // Fullness is sampled before any same-cycle pop, so a push into a full
   // FIFO is dropped even when a pop is accepted alongside it.
   assign w_push  = we_i && !w_full;

   generate
      if (FWFT) begin : g_fwft
         // count includes the word parked in the output register; the RAM
         // itself holds count minus that word.
         logic [AWIDTH:0] w_ram_cnt;
         assign w_ram_cnt = count_q - {{AWIDTH{1'b0}}, rvalid_q};
         assign w_pop     = re_i && rvalid_q;
         assign w_udf     = re_i && !rvalid_q;
         // Refill whenever the output register is free or being vacated,
         // which sustains one pop per cycle while RAM words remain.
         assign w_rd      = (w_ram_cnt != '0) && (!rvalid_q || w_pop);
         assign rvalid_d  = w_rd || (rvalid_q && !w_pop);
      end else begin : g_rreg
         assign w_pop     = re_i && !w_empty;
         assign w_udf     = re_i && w_empty;
         assign w_rd      = w_pop;
         assign rvalid_d  = w_pop;
      end
   endgenerate

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q || (we_i && w_full);
      udf_d   = udf_q || w_udf;
      if (w_push) begin
         wptr_d = wptr_q + 1'b1;
      end
      if (w_rd) begin
         rptr_d = rptr_q + 1'b1;
      end
      case ({w_push, w_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge ck_i) begin
      if (w_flush) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         rvalid_q <= 1'b0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         rvalid_q <= rvalid_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
         if (w_rd) begin
            rdata_q <= mem_q[rptr_q];
         end
      end
   end

   // Storage array carries no reset. Read and write never target the same
   // address on accepted operations, so read-during-write is irrelevant.
   always_ff @(posedge ck_i) begin
      if (w_push && !w_flush) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

   assign full_o      = w_full;
   assign afull_o     = (count_q >= c_afull);
   assign empty_o     = w_empty;
   assign aempty_o    = (count_q <= c_aempty);
   assign count_o     = count_q;
   assign rdata_o     = rdata_q;
   assign rvalid_o    = rvalid_q;
   assign overflow_o  = ovf_q;
   assign underflow_o = udf_q;

endmodule
`default_nettype wire
